// File: rtl/irq_ctrl_if.sv
// MMIO control bus shared by the peripherals: address plus active-low strobes.
// The data bus is bidirectional and stays a plain inout port on the peripheral.
interface irq_ctrl_if;
  logic [7:0] addr;
  logic       cs_;
  logic       oe_;
  logic       we_;

  modport master (output addr, cs_, oe_, we_);
  modport slave  (input  addr, cs_, oe_, we_);
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches up to 8 request lines as pending bits
// (level-following or rising-edge captured), masks them with EN and drives a
// registered CPU interrupt plus a priority-encoded vector (bit 0 highest).
module irq_ctrl #(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  irq_ctrl_if.slave       bus,
  inout  wire  [7:0]      data,
  input  logic [NSRC-1:0] src,
  output logic            irq,
  output logic [2:0]      irq_vec
);

  // Bits at NSRC and above never hold state.
  localparam logic [7:0] VALID = 8'((9'd1 << NSRC) - 9'd1);

  localparam logic [7:0] A_PEND = 8'd0;
  localparam logic [7:0] A_EN   = 8'd1;
  localparam logic [7:0] A_EDGE = 8'd2;
  localparam logic [7:0] A_VEC  = 8'd3;
  localparam logic [7:0] A_ACK  = 8'd4;

  logic [7:0] src_ext;
  logic [7:0] src_q;
  logic [7:0] pend;
  logic [7:0] en;
  logic [7:0] edge_sel;
  logic [7:0] rise;
  logic [7:0] clr;
  logic [7:0] pend_nxt;
  logic [7:0] active;
  logic [7:0] vec_rd;
  logic [7:0] rd_data;
  logic       wr;

  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    lowest_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_idx = 3'(i);
    end
  endfunction

  // Widen the request lines to the 8-bit register view.
  always_comb begin
    src_ext = 8'h00;
    src_ext[NSRC-1:0] = src;
  end

  assign wr     = ~bus.cs_ & ~bus.we_;
  assign rise   = src_ext & ~src_q;
  assign active = pend & en;

  // Clear requests from W1C on PEND and from an ACK index write.
  always_comb begin
    clr = 8'h00;
    if (wr && bus.addr == A_PEND) clr = data;
    if (wr && bus.addr == A_ACK)  clr = clr | (8'b1 << data[2:0]);
  end

  // Edge bits: a rise beats a same-cycle clear. Level bits simply follow src.
  always_comb begin
    pend_nxt = ((edge_sel & (rise | (pend & ~clr))) | (~edge_sel & src_ext)) & VALID;
  end

  // VEC read reports the live encode, 8'hFF when nothing is active.
  always_comb begin
    vec_rd = (|active) ? {5'b0, lowest_idx(active)} : 8'hFF;
  end

  // Register read mux; unmapped and write-only addresses read zero.
  always_comb begin
    rd_data = 8'h00;
    case (bus.addr)
      A_PEND:  rd_data = pend;
      A_EN:    rd_data = en;
      A_EDGE:  rd_data = edge_sel;
      A_VEC:   rd_data = vec_rd;
      default: rd_data = 8'h00;
    endcase
  end

  assign data = (~bus.cs_ & ~bus.oe_) ? rd_data : 8'bzzzzzzzz;

  // State update; src_q clears on reset so a line already high at release
  // is captured as a rising edge on the first clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q    <= 8'h00;
      pend     <= 8'h00;
      en       <= 8'h00;
      edge_sel <= 8'h00;
      irq      <= 1'b0;
      irq_vec  <= 3'd0;
    end else begin
      src_q <= src_ext;
      pend  <= pend_nxt;
      if (wr && bus.addr == A_EN)   en       <= data & VALID;
      if (wr && bus.addr == A_EDGE) edge_sel <= data & VALID;
      irq     <= |active;
      irq_vec <= lowest_idx(active);
    end
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
MMIO interrupt controller sitting directly downstream of the timer and other peripheral interrupt outputs. It samples up to 8 interrupt request lines and latches them as pending bits, either level-following or rising-edge captured. It masks them with an enable register and drives a single registered CPU interrupt plus a priority-encoded vector. It shares the same 8-bit chip-select/output-enable/write-enable bus protocol as the other MMIO peripherals.

Parameters:
NSRC, 8, number of interrupt source lines (1..8); register bits at index NSRC and above read 0 and ignore writes.

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
data  inout  8  MMIO data bus; driven only while ~cs_ & ~oe_, else 8'bzzzzzzzz
addr  input  8  MMIO register address
cs_  input  1  chip select, active low
oe_  input  1  output enable (read), active low
we_  input  1  write enable, active low
src  input  NSRC  interrupt request lines (timer interrupt on src[0]), synchronous to clk
irq  output  1  CPU interrupt request, registered
irq_vec  output  3  index of highest-priority enabled pending source, registered

Behaviour:
- Register map (addr): 0 PEND (R, W1C), 1 EN (R/W), 2 EDGE (R/W; 1 = edge mode, 0 = level mode), 3 VEC (R only; {5'b0, idx}, or 8'hFF if none), 4 ACK (W only; data[2:0] = index to clear; reads 8'h00). Any other addr: reads 8'h00, writes ignored.
- Read path: combinational, data = selected register while ~cs_ & ~oe_.
- Write: on posedge clk when ~cs_ & ~we_, using the data value present at that edge.
- src_q: registered copy of src each cycle; rise = src & ~src_q.
- Level-mode bit i: pend[i] <= src[i] every cycle; W1C and ACK have no effect.
- Edge-mode bit i: pend[i] set on rise[i]; cleared by a PEND write with data[i]=1 or an ACK write with data[2:0]==i. Set and clear in the same cycle: set wins, bit stays 1.
- Writing EDGE bit i from 1 to 0 hands that bit to level behaviour from the next cycle. Writing it from 0 to 1 keeps the current pend[i] value.
- active = pend & EN. irq <= |active. irq_vec <= index of the lowest-numbered set bit of active (bit 0 is highest priority), 3'd0 when none.
- VEC read returns the combinational encode of the current active value, not the registered irq_vec.
- Latency: src sampled high at edge k -> pend set after edge k -> irq/irq_vec valid after edge k+1. EN write at edge k -> irq reflects it after edge k+1.
- Reset (async, any time, including mid-write): pend=0, EN=0, EDGE=0, src_q=0, irq=0, irq_vec=0. A source already high at reset release counts as a rising edge on the first clock.
- Bits at index NSRC and above of pend/EN/EDGE are tied to 0.

Test Plan:
- Reset: assert rst mid-cycle with EN=8'hFF and PEND nonzero -> irq=0 and irq_vec=0 immediately; reads of addr 0,1,2 return 8'h00 and addr 3 returns 8'hFF after release.
- Level mode: EN=8'h01, src[0] high for 5 cycles then low -> irq rises 2 edges after src rises and falls 2 edges after src falls; W1C of 8'h01 while src high does not clear it.
- Edge mode with priority: EDGE=8'h0C, EN=8'h0C, pulse src[3] then src[2] one cycle each -> PEND=8'h0C, irq_vec=2; ACK 2 -> irq_vec=3; W1C 8'h08 -> irq=0 and VEC reads 8'hFF.
- Simultaneous set and clear: edge mode bit 1, rising edge on src[1] in the same cycle as W1C 8'h02 -> PEND[1] remains 1.
- Masking: pending bit 5 with EN=0 -> irq=0; write EN=8'h20 -> irq=1 and irq_vec=5 after one edge.
- Bus: read of addr 8'h10 returns 8'h00; data is Z when cs_=1 or oe_=1; a write to addr 3 leaves VEC unchanged.
